// File: rtl/fml_initiator_pkg.sv
// Shared FML memory-bus definitions used by the FML initiator.
package fml_initiator_pkg;

    localparam int unsigned FML_SDRAM_DEPTH = 26;
    localparam int unsigned FML_BEAT_W      = 64;
    localparam int unsigned FML_SEL_W       = 8;

endpackage

// File: rtl/fml_initiator.sv
// FML burst initiator: turns one 256-bit line request into a 4-beat FML
// write or read burst and reports completion with a one-cycle pulse.
module fml_initiator
    import fml_initiator_pkg::*;
#(
    parameter int unsigned sdram_depth  = FML_SDRAM_DEPTH,
    parameter int unsigned read_latency = 4
) (
    input  logic                   sys_clk,
    input  logic                   sys_rst,

    input  logic                   req_stb,
    output logic                   req_ack,
    input  logic                   req_we,
    input  logic [sdram_depth-6:0] req_adr,
    input  logic [31:0]            req_sel,
    input  logic [255:0]           req_wdat,
    output logic [255:0]           resp_rdat,
    output logic                   resp_done,
    output logic                   busy,

    output logic [sdram_depth-1:0] fml_adr,
    output logic                   fml_stb,
    output logic                   fml_we,
    input  logic                   fml_eack,
    output logic [7:0]             fml_sel,
    output logic [63:0]            fml_do,
    input  logic [63:0]            fml_di
);

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        WDATA,
        RWAIT,
        RDATA
    } state_t;

    localparam int unsigned BEATS      = 4;
    localparam logic [1:0]  LAST_BEAT  = 2'd3;
    // Wait cycles after the eack cycle before the first read beat, minus one.
    localparam logic [3:0]  RWAIT_INIT = 4'(read_latency - 2);

    state_t         state_q, state_d;
    logic [1:0]     beat_q, beat_d, beat_nxt;
    logic [3:0]     lat_q, lat_d;
    logic [31:0]    sel_q;
    logic [255:0]   wdat_q;

    logic           capture;
    logic           stb_d;
    logic           done_d;
    logic           busy_d;
    logic [7:0]     sel_d;
    logic [63:0]    do_d;
    logic [255:0]   rdat_d;

    // Acceptance is visible in the same cycle the request is seen in IDLE.
    assign req_ack = capture & ~sys_rst;

    // Next-state and next-output logic.
    always_comb begin
        state_d  = state_q;
        beat_d   = beat_q;
        lat_d    = lat_q;
        beat_nxt = beat_q + 2'd1;
        capture  = 1'b0;
        stb_d    = 1'b0;
        done_d   = 1'b0;
        sel_d    = '0;
        do_d     = '0;
        rdat_d   = resp_rdat;

        case (state_q)
            IDLE: begin
                if (req_stb) begin
                    capture = 1'b1;
                    stb_d   = 1'b1;
                    state_d = ADDR;
                end
            end
            ADDR: begin
                if (fml_eack) begin
                    beat_d = '0;
                    if (fml_we) begin
                        state_d = WDATA;
                        sel_d   = sel_q[7:0];
                        do_d    = wdat_q[63:0];
                    end else if (read_latency == 1) begin
                        state_d = RDATA;
                    end else begin
                        state_d = RWAIT;
                        lat_d   = RWAIT_INIT;
                    end
                end else begin
                    stb_d = 1'b1;
                end
            end
            WDATA: begin
                beat_d = beat_nxt;
                if (beat_q == LAST_BEAT) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else begin
                    sel_d = 8'(sel_q >> {beat_nxt, 3'b000});
                    do_d  = 64'(wdat_q >> {beat_nxt, 6'b000000});
                end
            end
            RWAIT: begin
                if (lat_q == '0) begin
                    state_d = RDATA;
                end else begin
                    lat_d = lat_q - 4'd1;
                end
            end
            RDATA: begin
                for (int k = 0; k < BEATS; k++) begin
                    if (beat_q == 2'(k)) begin
                        rdat_d[k*64 +: 64] = fml_di;
                    end
                end
                beat_d = beat_nxt;
                if (beat_q == LAST_BEAT) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    // State register.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q <= IDLE;
            beat_q  <= '0;
            lat_q   <= '0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            lat_q   <= lat_d;
        end
    end

    // Registered outputs and captured request.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            fml_stb   <= 1'b0;
            fml_we    <= 1'b0;
            fml_adr   <= '0;
            fml_sel   <= '0;
            fml_do    <= '0;
            resp_done <= 1'b0;
            resp_rdat <= '0;
            busy      <= 1'b0;
            sel_q     <= '0;
            wdat_q    <= '0;
        end else begin
            fml_stb   <= stb_d;
            fml_sel   <= sel_d;
            fml_do    <= do_d;
            resp_done <= done_d;
            resp_rdat <= rdat_d;
            busy      <= busy_d;
            if (capture) begin
                fml_adr <= {req_adr, 5'b00000};
                fml_we  <= req_we;
                sel_q   <= req_sel;
                wdat_q  <= req_wdat;
            end
        end
    end

endmodule

// File: tb/tb_fml_initiator.sv
// Directed bench for fml_initiator: a vector table of bursts plus hand-written
// sequences for held request strobe and reset in the middle of a read.
module tb_fml_initiator;

    localparam int RL = 4;

    logic           sys_clk;
    logic           sys_rst;
    logic           req_stb;
    logic           req_ack;
    logic           req_we;
    logic [20:0]    req_adr;
    logic [31:0]    req_sel;
    logic [255:0]   req_wdat;
    logic [255:0]   resp_rdat;
    logic           resp_done;
    logic           busy;
    logic [25:0]    fml_adr;
    logic           fml_stb;
    logic           fml_we;
    logic           fml_eack;
    logic [7:0]     fml_sel;
    logic [63:0]    fml_do;
    logic [63:0]    fml_di;

    fml_initiator #(.sdram_depth(26), .read_latency(RL)) dut (
        .sys_clk  (sys_clk),
        .sys_rst  (sys_rst),
        .req_stb  (req_stb),
        .req_ack  (req_ack),
        .req_we   (req_we),
        .req_adr  (req_adr),
        .req_sel  (req_sel),
        .req_wdat (req_wdat),
        .resp_rdat(resp_rdat),
        .resp_done(resp_done),
        .busy     (busy),
        .fml_adr  (fml_adr),
        .fml_stb  (fml_stb),
        .fml_we   (fml_we),
        .fml_eack (fml_eack),
        .fml_sel  (fml_sel),
        .fml_do   (fml_do),
        .fml_di   (fml_di)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    typedef struct {
        logic             we;
        logic [20:0]      adr;
        logic [31:0]      sel;
        logic [3:0][63:0] wdat;
        logic [3:0][63:0] rdat_in;
        int               eack_wait;
        logic [25:0]      exp_adr;
        logic [3:0][7:0]  exp_sel;
        logic [255:0]     exp_rdat;
    } vec_t;

    vec_t vec [6];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic check(input string nm, input logic [255:0] act, input logic [255:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Issues vec[i] at the current negedge; returns at the negedge of the done cycle.
    task automatic run_txn(input int i);
        vec_t v;
        int   last;
        v = vec[i];
        req_stb  = 1'b1;
        req_we   = v.we;
        req_adr  = v.adr;
        req_sel  = v.sel;
        req_wdat = v.wdat;
        #1;
        check($sformatf("v%0d req_ack", i), 256'(req_ack), 256'(1));
        @(negedge sys_clk);
        req_stb  = 1'b0;
        req_we   = ~v.we;
        req_adr  = '0;
        req_sel  = '0;
        req_wdat = '0;
        for (int w = 0; w <= v.eack_wait; w++) begin
            check($sformatf("v%0d addr stb", i), 256'(fml_stb), 256'(1));
            check($sformatf("v%0d addr adr", i), 256'(fml_adr), 256'(v.exp_adr));
            check($sformatf("v%0d addr we", i), 256'(fml_we), 256'(v.we));
            check($sformatf("v%0d addr busy", i), 256'(busy), 256'(1));
            fml_eack = (w == v.eack_wait);
            @(negedge sys_clk);
        end
        fml_eack = 1'b0;
        last = v.we ? 5 : RL + 4;
        for (int c = 1; c <= last; c++) begin
            if (!v.we) begin
                fml_di = (c >= RL && c < RL + 4) ? v.rdat_in[2'(c - RL)] : 64'hBAD0_BAD0_BAD0_BAD0;
            end
            if (c == last) begin
                check($sformatf("v%0d done", i), 256'(resp_done), 256'(1));
                check($sformatf("v%0d done busy", i), 256'(busy), 256'(0));
                check($sformatf("v%0d rdat", i), resp_rdat, v.exp_rdat);
                check($sformatf("v%0d done sel", i), 256'(fml_sel), 256'(0));
                check($sformatf("v%0d done do", i), 256'(fml_do), 256'(0));
            end else begin
                check($sformatf("v%0d c%0d early done", i, c), 256'(resp_done), 256'(0));
                check($sformatf("v%0d c%0d stb low", i, c), 256'(fml_stb), 256'(0));
                check($sformatf("v%0d c%0d busy", i, c), 256'(busy), 256'(1));
                if (v.we && c <= 4) begin
                    check($sformatf("v%0d c%0d sel", i, c), 256'(fml_sel), 256'(v.exp_sel[2'(c - 1)]));
                    check($sformatf("v%0d c%0d do", i, c), 256'(fml_do), 256'(v.wdat[2'(c - 1)]));
                end else begin
                    check($sformatf("v%0d c%0d sel idle", i, c), 256'(fml_sel), 256'(0));
                    check($sformatf("v%0d c%0d do idle", i, c), 256'(fml_do), 256'(0));
                end
                @(negedge sys_clk);
            end
        end
        fml_di = '0;
    endtask

    initial begin
        int n_ack;
        int ack2_cyc;
        int done_cnt;

        vec[0] = '{we: 1'b1, adr: 21'h123, sel: 32'hFFFF_FFFF,
                   wdat: {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                          64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111},
                   rdat_in: '0, eack_wait: 2, exp_adr: 26'h2460,
                   exp_sel: {8'hFF, 8'hFF, 8'hFF, 8'hFF}, exp_rdat: '0};
        vec[1] = '{we: 1'b0, adr: 21'h0AB, sel: 32'h0,
                   wdat: '0, rdat_in: {64'hA3, 64'hA2, 64'hA1, 64'hA0},
                   eack_wait: 0, exp_adr: 26'h1560, exp_sel: '0,
                   exp_rdat: {64'hA3, 64'hA2, 64'hA1, 64'hA0}};
        vec[2] = '{we: 1'b1, adr: 21'h001, sel: 32'h0F00_00F0,
                   wdat: {64'hDDDD_0000_0000_0003, 64'hCCCC_0000_0000_0002,
                          64'hBBBB_0000_0000_0001, 64'hAAAA_0000_0000_0000},
                   rdat_in: '0, eack_wait: 0, exp_adr: 26'h0000020,
                   exp_sel: {8'h0F, 8'h00, 8'h00, 8'hF0},
                   exp_rdat: {64'hA3, 64'hA2, 64'hA1, 64'hA0}};
        vec[3] = '{we: 1'b0, adr: 21'h1F_FFFF, sel: 32'h0, wdat: '0,
                   rdat_in: {64'hAAAA_AAAA_AAAA_AAAA, 64'h5555_5555_5555_5555,
                             64'hFEDC_BA98_7654_3210, 64'h0123_4567_89AB_CDEF},
                   eack_wait: 1, exp_adr: 26'h3FF_FFE0, exp_sel: '0,
                   exp_rdat: {64'hAAAA_AAAA_AAAA_AAAA, 64'h5555_5555_5555_5555,
                              64'hFEDC_BA98_7654_3210, 64'h0123_4567_89AB_CDEF}};
        vec[4] = '{we: 1'b1, adr: 21'h000, sel: 32'h8040_2010,
                   wdat: {64'h0F0F_0F0F_0F0F_0F0F, 64'hF0F0_F0F0_F0F0_F0F0,
                          64'h8000_0000_0000_0001, 64'hFFFF_FFFF_FFFF_FFFF},
                   rdat_in: '0, eack_wait: 100, exp_adr: 26'h0,
                   exp_sel: {8'h80, 8'h40, 8'h20, 8'h10},
                   exp_rdat: {64'hAAAA_AAAA_AAAA_AAAA, 64'h5555_5555_5555_5555,
                              64'hFEDC_BA98_7654_3210, 64'h0123_4567_89AB_CDEF}};
        vec[5] = '{we: 1'b1, adr: 21'h0_5A5A, sel: 32'h0000_0001,
                   wdat: {64'h4, 64'h3, 64'h2, 64'h1},
                   rdat_in: '0, eack_wait: 0, exp_adr: 26'h00B_4B40,
                   exp_sel: {8'h00, 8'h00, 8'h00, 8'h01}, exp_rdat: '0};

        sys_rst  = 1'b1;
        req_stb  = 1'b1;
        req_we   = 1'b0;
        req_adr  = '0;
        req_sel  = '0;
        req_wdat = '0;
        fml_eack = 1'b0;
        fml_di   = '0;

        // Reset values with a request already pending.
        @(negedge sys_clk);
        check("rst req_ack", 256'(req_ack), 256'(0));
        check("rst stb", 256'(fml_stb), 256'(0));
        check("rst busy", 256'(busy), 256'(0));
        check("rst done", 256'(resp_done), 256'(0));
        check("rst adr", 256'(fml_adr), 256'(0));
        check("rst sel", 256'(fml_sel), 256'(0));
        check("rst do", 256'(fml_do), 256'(0));
        check("rst rdat", resp_rdat, 256'(0));
        req_stb = 1'b0;
        sys_rst = 1'b0;
        @(negedge sys_clk);

        // Table-driven bursts, issued back to back in each done cycle.
        for (int i = 0; i < 5; i++) begin
            run_txn(i);
        end
        req_stb = 1'b0;
        @(negedge sys_clk);

        // Held request strobe: read then write, one ack each, second in the done cycle.
        n_ack    = 0;
        ack2_cyc = -1;
        fml_eack = 1'b1;
        req_stb  = 1'b1;
        req_we   = 1'b0;
        req_adr  = 21'h00_0042;
        req_sel  = 32'hFFFF_FFFF;
        req_wdat = '0;
        for (int c = 0; c <= 15; c++) begin
            if (c == 1) req_we = 1'b1;
            if (c == 15) req_stb = 1'b0;
            fml_di = 64'(c);
            #1;
            if (req_ack) begin
                n_ack++;
                if (n_ack == 2) ack2_cyc = c;
                check($sformatf("held c%0d ack while busy", c), 256'(busy), 256'(0));
            end
            if (c == 9) begin
                check("held read done", 256'(resp_done), 256'(1));
                check("held read rdat", resp_rdat, {64'd8, 64'd7, 64'd6, 64'd5});
            end
            if (c == 15) check("held write done", 256'(resp_done), 256'(1));
            @(negedge sys_clk);
        end
        fml_eack = 1'b0;
        fml_di   = '0;
        check("held ack count", 256'(n_ack), 256'(2));
        check("held second ack cycle", 256'(ack2_cyc), 256'(9));
        check("held idle after", 256'(busy), 256'(0));

        // Reset while waiting for read data.
        req_stb = 1'b1;
        req_we  = 1'b0;
        req_adr = 21'h00_0005;
        @(negedge sys_clk);
        fml_eack = 1'b1;
        @(negedge sys_clk);
        fml_eack = 1'b0;
        @(negedge sys_clk);
        check("pre-rst in rwait busy", 256'(busy), 256'(1));
        sys_rst = 1'b1;
        #1;
        check("mid-rst stb", 256'(fml_stb), 256'(0));
        check("mid-rst busy", 256'(busy), 256'(0));
        check("mid-rst done", 256'(resp_done), 256'(0));
        check("mid-rst req_ack", 256'(req_ack), 256'(0));
        check("mid-rst rdat", resp_rdat, 256'(0));
        @(negedge sys_clk);
        @(negedge sys_clk);
        req_stb = 1'b0;
        sys_rst = 1'b0;
        done_cnt = 0;
        for (int c = 0; c < 12; c++) begin
            #1;
            if (resp_done || req_ack || busy) done_cnt++;
            @(negedge sys_clk);
        end
        check("post-rst activity", 256'(done_cnt), 256'(0));

        // A write after reset still works and leaves resp_rdat at its reset value.
        run_txn(5);
        req_stb = 1'b0;
        @(negedge sys_clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
